// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM states and FIFO entry layout.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_t;

  localparam int ENTRY_W = 11;

  typedef struct packed {
    logic       brk;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through FIFO; the head is a register loaded from the array or bypassed
// from the write port when the written slot becomes the next head.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                   rxclk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      level_reg;
  logic [WIDTH-1:0] head_reg;
  logic             do_push, do_pop;

  assign full        = (level_reg == (AW+1)'(DEPTH));
  assign empty       = (level_reg == '0);
  assign do_pop      = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push     = push && (!full || do_pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
  assign level       = level_reg;
  assign rdata       = head_reg;

  always_ff @(posedge rxclk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
      head_reg   <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? wdata : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 2-of-3 bit voting, error/break flags and an FWFT output FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        rxclk,
  input  logic                        reset_n,
  input  logic                        rx_in,
  input  logic                        rx_en,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  output logic [7:0]                  m_data,
  output logic                        m_frame_err,
  output logic                        m_parity_err,
  output logic                        m_break,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  input  logic                        clr_overrun
);
  localparam int S_W = $clog2(OVERSAMPLE);
  localparam logic [S_W-1:0] S_LO   = S_W'(OVERSAMPLE/2 - 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE/2);
  localparam logic [S_W-1:0] S_HI   = S_W'(OVERSAMPLE/2 + 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);

  logic [1:0]       sync_reg;
  logic             rxs;
  logic [DIV_W-1:0] tick_cnt_reg;
  logic             tick;
  rx_state_t        state_reg;
  logic [S_W-1:0]   s_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             v0_reg, v1_reg, par_bit_reg, par_err_reg, frame_err_reg, stop_cnt_reg;
  logic             overrun_reg;
  logic             vote, decide, has_par, last_stop, frame_err_final, is_break;
  logic             push, pop, fifo_full, fifo_empty;
  rx_entry_t        push_entry, head_entry;

  assign rxs  = sync_reg[1];
  assign tick = (tick_cnt_reg == '0);

  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      sync_reg     <= 2'b11;
      tick_cnt_reg <= '0;
    end else begin
      sync_reg     <= {sync_reg[0], rx_in};
      tick_cnt_reg <= tick ? baud_div : tick_cnt_reg - DIV_W'(1);
    end
  end

  always_comb begin
    vote            = maj3(v0_reg, v1_reg, rxs);
    decide          = tick && (s_reg == S_HI);
    has_par         = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    last_stop       = (STOP_BITS == 1) || stop_cnt_reg;
    frame_err_final = frame_err_reg | ~vote;
    is_break        = (shift_reg == 8'h00) && !par_bit_reg && frame_err_final;
    push            = rx_en && (state_reg == ST_STOP) && decide && last_stop;
    push_entry      = '0;
    if (is_break) begin
      push_entry.brk       = 1'b1;
      push_entry.frame_err = 1'b1;
    end else begin
      push_entry.parity_err = par_err_reg;
      push_entry.frame_err  = frame_err_final;
      push_entry.data       = shift_reg;
    end
  end

  // Sample counter keeps running across bit boundaries, so each state acts at its bit centre.
  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      s_reg         <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      v0_reg        <= 1'b1;
      v1_reg        <= 1'b1;
      par_bit_reg   <= 1'b0;
      par_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      stop_cnt_reg  <= 1'b0;
    end else if (!rx_en) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!rxs) begin
            state_reg     <= ST_START;
            s_reg         <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            par_bit_reg   <= 1'b0;
            par_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            stop_cnt_reg  <= 1'b0;
          end
        end
        ST_WAIT_HI: begin
          if (rxs) state_reg <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            s_reg <= (s_reg == S_LAST) ? '0 : s_reg + S_W'(1);
            if (s_reg == S_LO)  v0_reg <= rxs;
            if (s_reg == S_MID) v1_reg <= rxs;
            if (s_reg == S_HI) begin
              case (state_reg)
                ST_START: state_reg <= vote ? ST_IDLE : ST_DATA;
                ST_DATA: begin
                  shift_reg[bit_cnt_reg] <= vote;
                  bit_cnt_reg            <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'(DATA_BITS - 1))
                    state_reg <= has_par ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                  par_bit_reg <= vote;
                  par_err_reg <= (^shift_reg) ^ vote ^ (parity_mode == PAR_ODD);
                  state_reg   <= ST_STOP;
                end
                ST_STOP: begin
                  if (last_stop) begin
                    state_reg <= is_break ? ST_WAIT_HI : ST_IDLE;
                  end else begin
                    frame_err_reg <= frame_err_final;
                    stop_cnt_reg  <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge rxclk) begin
    if (!reset_n)                         overrun_reg <= 1'b0;
    else if (push && fifo_full && !pop)   overrun_reg <= 1'b1;
    else if (clr_overrun)                 overrun_reg <= 1'b0;
  end
  assign overrun = overrun_reg;

  uart_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .rxclk  (rxclk),
    .reset_n(reset_n),
    .push   (push),
    .wdata  (push_entry),
    .pop    (pop),
    .rdata  (head_entry),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_data
      if (gi < DATA_BITS) begin : g_live
        assign m_data[gi] = head_entry.data[gi];
      end else begin : g_zero
        assign m_data[gi] = 1'b0;
      end
    end
  endgenerate

  assign m_frame_err  = head_entry.frame_err;
  assign m_parity_err = head_entry.parity_err;
  assign m_break      = head_entry.brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8-bit/4-deep receiver on one line, 7-bit/2-stop receiver on a second line.
module tb_uart_rx_fifo;

  logic        rxclk = 1'b0;
  logic        reset_n, rx_in, rx2, rx_en, m_ready, m_ready2, clr_overrun;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic [7:0]  m_data, m2_data;
  logic        m_frame_err, m_parity_err, m_break, m_valid, overrun;
  logic        m2_frame_err, m2_parity_err, m2_break, m2_valid, overrun2;
  logic [2:0]  fifo_level;
  logic [4:0]  m2_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc, vcyc, lat;
  bit arm = 1'b0;

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;
  always @(negedge rxclk) if (arm && m_valid) begin arm = 1'b0; vcyc = cyc; end

  uart_rx_fifo #(.FIFO_DEPTH(4)) dut (
    .rxclk(rxclk), .reset_n(reset_n), .rx_in(rx_in), .rx_en(rx_en), .baud_div(baud_div),
    .parity_mode(parity_mode), .m_data(m_data), .m_frame_err(m_frame_err),
    .m_parity_err(m_parity_err), .m_break(m_break), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .overrun(overrun), .clr_overrun(clr_overrun));

  uart_rx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .rxclk(rxclk), .reset_n(reset_n), .rx_in(rx2), .rx_en(rx_en), .baud_div(baud_div),
    .parity_mode(parity_mode), .m_data(m2_data), .m_frame_err(m2_frame_err),
    .m_parity_err(m2_parity_err), .m_break(m2_break), .m_valid(m2_valid), .m_ready(m_ready2),
    .fifo_level(m2_level), .overrun(overrun2), .clr_overrun(clr_overrun));

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    bit         pb;
    bit         stop;
    logic [7:0] ed;
    bit         epe, efe, ebrk;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rxclk);
  endtask

  task automatic drive_bit(input bit sel, input bit b);
    if (sel) rx2 = b; else rx_in = b;
    idle(16);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input int nb, input bit pen,
                            input bit pb, input int ns, input bit s1, input bit s2);
    if (!sel) begin start_cyc = cyc; arm = 1'b1; end
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (pen) drive_bit(sel, pb);
    drive_bit(sel, s1);
    if (ns == 2) drive_bit(sel, s2);
    drive_bit(sel, 1'b1);
    drive_bit(sel, 1'b1);
  endtask

  task automatic expect_entry(input bit sel, input string name, input logic [7:0] ed,
                              input bit epe, input bit efe, input bit ebrk);
    int   n;
    logic v;
    n = 0;
    v = sel ? m2_valid : m_valid;
    while (!v && n < 200) begin
      @(negedge rxclk);
      n++;
      v = sel ? m2_valid : m_valid;
    end
    check({name, ".valid"}, v, 1);
    if (v) begin
      check({name, ".data"}, sel ? m2_data : m_data, ed);
      check({name, ".perr"}, sel ? m2_parity_err : m_parity_err, epe);
      check({name, ".ferr"}, sel ? m2_frame_err : m_frame_err, efe);
      check({name, ".brk"},  sel ? m2_break : m_break, ebrk);
      if (sel) m_ready2 = 1'b1; else m_ready = 1'b1;
      @(negedge rxclk);
      m_ready  = 1'b0;
      m_ready2 = 1'b0;
    end
  endtask

  initial begin
    //          d      pm    pb    stop  ed     pe fe brk
    vecs[0]  = '{8'h55, 2'd0, 1'b0, 1'b1, 8'h55, 0, 0, 0};
    vecs[1]  = '{8'hA3, 2'd1, 1'b1, 1'b1, 8'hA3, 1, 0, 0};
    vecs[2]  = '{8'hA3, 2'd1, 1'b0, 1'b1, 8'hA3, 0, 0, 0};
    vecs[3]  = '{8'hA3, 2'd2, 1'b0, 1'b1, 8'hA3, 1, 0, 0};
    vecs[4]  = '{8'h0F, 2'd2, 1'b1, 1'b1, 8'h0F, 0, 0, 0};
    vecs[5]  = '{8'h80, 2'd0, 1'b0, 1'b0, 8'h80, 0, 1, 0};
    vecs[6]  = '{8'hFF, 2'd0, 1'b0, 1'b1, 8'hFF, 0, 0, 0};
    vecs[7]  = '{8'h00, 2'd1, 1'b0, 1'b1, 8'h00, 0, 0, 0};
    vecs[8]  = '{8'h3C, 2'd3, 1'b1, 1'b1, 8'h3C, 0, 0, 0};
    vecs[9]  = '{8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 0, 1, 1};
    vecs[10] = '{8'h00, 2'd1, 1'b1, 1'b0, 8'h00, 1, 1, 0};

    reset_n = 1'b0; rx_in = 1'b1; rx2 = 1'b1; rx_en = 1'b1; m_ready = 1'b0; m_ready2 = 1'b0;
    clr_overrun = 1'b0; baud_div = 16'd0; parity_mode = 2'd0;
    idle(3);
    check("reset.valid", m_valid, 0);
    check("reset.level", fifo_level, 0);
    check("reset.overrun", overrun, 0);
    check("reset.data", m_data, 0);
    check("reset.flags", {m_frame_err, m_parity_err, m_break}, 0);
    reset_n = 1'b1;
    idle(5);

    // Short low pulse must be rejected by the start-bit vote.
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(40);
    check("glitch.level", fifo_level, 0);
    check("glitch.valid", m_valid, 0);

    for (int i = 0; i < 11; i++) begin
      parity_mode = vecs[i].pm;
      send_frame(1'b0, vecs[i].d, 8, (vecs[i].pm == 2'd1) || (vecs[i].pm == 2'd2),
                 vecs[i].pb, 1, vecs[i].stop, 1'b1);
      if (i == 0) begin
        // Stop-bit centre is 9.5 bit times after the edge, plus synchroniser and push latency.
        lat = vcyc - start_cyc;
        checks++;
        if (arm || lat < 150 || lat > 162) begin
          errors++;
          $display("FAIL latency: got %0d cycles (seen=%0d), expected 150..162", lat, !arm);
        end
      end
      expect_entry(1'b0, $sformatf("vec%0d", i), vecs[i].ed, vecs[i].epe, vecs[i].efe,
                   vecs[i].ebrk);
    end
    parity_mode = 2'd0;

    // Line held low for 20 bit times: exactly one break entry.
    rx_in = 1'b0;
    idle(20 * 16);
    rx_in = 1'b1;
    idle(32);
    check("break.level", fifo_level, 1);
    expect_entry(1'b0, "break", 8'h00, 0, 1, 1);
    check("break.level_after", fifo_level, 0);
    send_frame(1'b0, 8'h41, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    expect_entry(1'b0, "after_break", 8'h41, 0, 0, 0);

    // Overrun on the fifth frame into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) send_frame(1'b0, 8'(i), 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    check("ovr.level", fifo_level, 4);
    check("ovr.flag", overrun, 1);
    for (int i = 1; i <= 4; i++) expect_entry(1'b0, $sformatf("drain%0d", i), 8'(i), 0, 0, 0);
    check("ovr.level_empty", fifo_level, 0);
    check("ovr.sticky", overrun, 1);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    check("ovr.cleared", overrun, 0);

    // Reset mid-frame discards both FIFO contents and the partial frame.
    send_frame(1'b0, 8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    check("rst.level_before", fifo_level, 1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    reset_n = 1'b0;
    idle(1);
    rx_in   = 1'b1;
    reset_n = 1'b1;
    check("rst.level", fifo_level, 0);
    check("rst.valid", m_valid, 0);
    check("rst.data", m_data, 0);
    idle(48);
    check("rst.level_idle", fifo_level, 0);
    send_frame(1'b0, 8'h7E, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    expect_entry(1'b0, "after_rst", 8'h7E, 0, 0, 0);

    // Disable mid-frame: the rest of the frame must not produce an entry.
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    rx_en = 1'b0;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    idle(32);
    rx_en = 1'b1;
    idle(32);
    check("rxen.level", fifo_level, 0);
    send_frame(1'b0, 8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    expect_entry(1'b0, "after_rxen", 8'h5A, 0, 0, 0);

    // 7 data bits, odd parity, two stop bits.
    parity_mode = 2'd2;
    send_frame(1'b1, 8'h7F, 7, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    expect_entry(1'b1, "d7.ok", 8'h7F, 0, 0, 0);
    send_frame(1'b1, 8'h7F, 7, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    expect_entry(1'b1, "d7.stop2", 8'h7F, 0, 1, 0);
    send_frame(1'b1, 8'h7F, 7, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    expect_entry(1'b1, "d7.stop1", 8'h7F, 0, 1, 0);
    send_frame(1'b1, 8'h7F, 7, 1'b1, 1'b1, 2, 1'b1, 1'b1);
    expect_entry(1'b1, "d7.perr", 8'h7F, 1, 0, 0);
    send_frame(1'b1, 8'h55, 7, 1'b1, 1'b1, 2, 1'b1, 1'b1);
    expect_entry(1'b1, "d7.55", 8'h55, 0, 0, 0);
    check("d7.level", m2_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded 1 ms");
    $fatal(1);
  end

endmodule
